// File: rtl/mem_burst_pkg.sv
// Purpose : shared types for the memory burst master (FSM states, direction codes).
// Latency : n/a (types only).
// Backpressure: n/a.
package mem_burst_pkg;

   // Sequencer states; outputs are decoded from the registered state.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_FETCH = 3'd1,
      WR_REQ   = 3'd2,
      RD_REQ   = 3'd3,
      RD_OUT   = 3'd4,
      DONE     = 3'd5
   } state_e;

   localparam logic DIR_RD = 1'b0;
   localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/mem_burst_addr_gen.sv
// Purpose : burst address/count tracker; loads start address and length, steps per word.
// Latency : registered; addr_o/last_o reflect a load or increment on the following cycle.
// Backpressure: none; steps only when the owning FSM pulses inc_i.
// Ports: clk_i/clr_i clock and sync active-high reset; load_i/addr_i/len_i latch a new burst;
//        inc_i advances address and count; addr_o current word address; last_o count==len.
module mem_burst_addr_gen #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  clr_i,
   input  logic                  load_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [ADDR_WIDTH-1:0] len_i,
   input  logic                  inc_i,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  last_o
);

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] len_q, len_d;
   // One bit wider than the address so a full-memory burst (len = DEPTH-1) never aliases.
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

   always_comb begin
      addr_d = addr_q;
      len_d  = len_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         addr_d = addr_i;
         len_d  = len_i;
         cnt_d  = '0;
      end else if (inc_i) begin
         // Address wraps naturally modulo 2^ADDR_WIDTH.
         addr_d = addr_q + ADDR_WIDTH'(1);
         cnt_d  = cnt_q + (ADDR_WIDTH+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         addr_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
      end else begin
         addr_q <= addr_d;
         len_q  <= len_d;
         cnt_q  <= cnt_d;
      end
   end

   assign addr_o = addr_q;
   assign last_o = (cnt_q == {1'b0, len_q});

endmodule

// File: rtl/mem_burst_master.sv
// Purpose : burst sequencer driving a single-port SRAM one valid/ready word at a time.
// Latency : cmd->first mem request 1 cycle (read) / 2 cycles (write); >=2 cycles per word + 1 DONE cycle.
// Backpressure: write data starvation parks in WR_FETCH, read backpressure parks in RD_OUT, mem stalls park in *_REQ.
// Ports: cmd_* burst command (dir, start addr, len = words-1); wr_* write data in; rd_* read data out
//        with rd_last_o on the final word; mem_* SRAM request/response; busy_o not idle; done_o end pulse.
// Build option: MEM_BURST_TIMEOUT_EN adds a memory watchdog and the sticky err_o output.
module mem_burst_master
   import mem_burst_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int DEPTH          = 16,
   parameter int ADDR_WIDTH     = $clog2(DEPTH),
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk_i,
   input  logic                  clr_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_wr_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [ADDR_WIDTH-1:0] cmd_len_i,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic [WIDTH-1:0]      wr_data_i,
   output logic                  rd_valid_o,
   input  logic                  rd_ready_i,
   output logic [WIDTH-1:0]      rd_data_o,
   output logic                  rd_last_o,
   output logic                  mem_valid_o,
   output logic                  mem_wr_rd_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [WIDTH-1:0]      mem_wdata_o,
   input  logic                  mem_ready_i,
   input  logic [WIDTH-1:0]      mem_rdata_i,
`ifdef MEM_BURST_TIMEOUT_EN
   output logic                  err_o,
`endif
   output logic                  busy_o,
   output logic                  done_o
);

   state_e           state_q, state_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;

   logic             ag_load, ag_inc, ag_last;
   logic [ADDR_WIDTH-1:0] ag_addr;

   mem_burst_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .clk_i  (clk_i),
      .clr_i  (clr_i),
      .load_i (ag_load),
      .addr_i (cmd_addr_i),
      .len_i  (cmd_len_i),
      .inc_i  (ag_inc),
      .addr_o (ag_addr),
      .last_o (ag_last)
   );

`ifdef MEM_BURST_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;
   logic            in_req, wd_expire;

   assign in_req = (state_q == WR_REQ) || (state_q == RD_REQ);
   // Fires on the edge that would make the stall TIMEOUT_CYCLES long, so DONE
   // is entered exactly TIMEOUT_CYCLES cycles after mem_valid_o rose.
   assign wd_expire = in_req && !mem_ready_i && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wd_d  = '0;
      err_d = err_q;
      if (in_req && !mem_ready_i) begin
         wd_d = wd_q + WD_W'(1);
      end
      if (state_q == IDLE && cmd_valid_i) begin
         err_d = 1'b0;
      end
      if (wd_expire) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   // Keeps the watchdog parameter referenced when the watchdog is compiled out.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      ag_load     = 1'b0;
      ag_inc      = 1'b0;
      cmd_ready_o = 1'b0;
      wr_ready_o  = 1'b0;
      rd_valid_o  = 1'b0;
      rd_last_o   = 1'b0;
      mem_valid_o = 1'b0;
      done_o      = 1'b0;

      case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               ag_load = 1'b1;
               dir_d   = cmd_wr_i ? DIR_WR : DIR_RD;
               state_d = cmd_wr_i ? WR_FETCH : RD_REQ;
            end
         end
         WR_FETCH: begin
            wr_ready_o = 1'b1;
            if (wr_valid_i) begin
               wdata_d = wr_data_i;
               state_d = WR_REQ;
            end
         end
         WR_REQ: begin
            mem_valid_o = 1'b1;
            if (mem_ready_i) begin
               if (ag_last) begin
                  state_d = DONE;
               end else begin
                  ag_inc  = 1'b1;
                  state_d = WR_FETCH;
               end
            end
         end
         RD_REQ: begin
            mem_valid_o = 1'b1;
            if (mem_ready_i) begin
               rdata_d = mem_rdata_i;
               state_d = RD_OUT;
            end
         end
         RD_OUT: begin
            rd_valid_o = 1'b1;
            rd_last_o  = ag_last;
            if (rd_ready_i) begin
               if (ag_last) begin
                  state_d = DONE;
               end else begin
                  ag_inc  = 1'b1;
                  state_d = RD_REQ;
               end
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef MEM_BURST_TIMEOUT_EN
      // Abandon the stalled request; DONE drops mem_valid_o.
      if (wd_expire) begin
         state_d = DONE;
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         state_q <= IDLE;
         dir_q   <= DIR_RD;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Direction is only meaningful while a request is on the bus.
   assign mem_wr_rd_en_o = mem_valid_o && (dir_q == DIR_WR);
   assign mem_addr_o     = ag_addr;
   assign mem_wdata_o    = wdata_q;
   assign rd_data_o      = rdata_q;
   assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_burst_master.sv
// Purpose : self-checking bench for mem_burst_master with a behavioural SRAM and reference memory.
// Latency : n/a.
// Backpressure: bench drives random or fixed memory ready, write data gaps and read stalls.
module tb_mem_burst_master;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic             clr_i, cmd_valid_i, cmd_ready_o, cmd_wr_i;
   logic [AW-1:0]    cmd_addr_i, cmd_len_i;
   logic             wr_valid_i, wr_ready_o;
   logic [WIDTH-1:0] wr_data_i;
   logic             rd_valid_o, rd_ready_i, rd_last_o;
   logic [WIDTH-1:0] rd_data_o;
   logic             mem_valid_o, mem_wr_rd_en_o, mem_ready_i;
   logic [AW-1:0]    mem_addr_o;
   logic [WIDTH-1:0] mem_wdata_o, mem_rdata_i;
   logic             busy_o, done_o;
`ifdef MEM_BURST_TIMEOUT_EN
   logic             err_o;
`endif

   mem_burst_master #(
      .WIDTH          (WIDTH),
      .DEPTH          (DEPTH),
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i          (clk_i),
      .clr_i          (clr_i),
      .cmd_valid_i    (cmd_valid_i),
      .cmd_ready_o    (cmd_ready_o),
      .cmd_wr_i       (cmd_wr_i),
      .cmd_addr_i     (cmd_addr_i),
      .cmd_len_i      (cmd_len_i),
      .wr_valid_i     (wr_valid_i),
      .wr_ready_o     (wr_ready_o),
      .wr_data_i      (wr_data_i),
      .rd_valid_o     (rd_valid_o),
      .rd_ready_i     (rd_ready_i),
      .rd_data_o      (rd_data_o),
      .rd_last_o      (rd_last_o),
      .mem_valid_o    (mem_valid_o),
      .mem_wr_rd_en_o (mem_wr_rd_en_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_ready_i    (mem_ready_i),
      .mem_rdata_i    (mem_rdata_i),
`ifdef MEM_BURST_TIMEOUT_EN
      .err_o          (err_o),
`endif
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   // Behavioural SRAM plus a log of every write transaction it accepts.
   logic [WIDTH-1:0] mem_arr [DEPTH];
   logic [AW-1:0]    wlog_addr [$];
   logic [WIDTH-1:0] wlog_data [$];
   always @(posedge clk_i) begin
      if (mem_valid_o && mem_ready_i && mem_wr_rd_en_o) begin
         mem_arr[mem_addr_o] <= mem_wdata_o;
         wlog_addr.push_back(mem_addr_o);
         wlog_data.push_back(mem_wdata_o);
      end
   end
   assign mem_rdata_i = mem_arr[mem_addr_o];

   int done_cnt = 0;
   always @(posedge clk_i) if (done_o) done_cnt <= done_cnt + 1;

   logic [WIDTH-1:0] ref_mem [DEPTH];
   logic [WIDTH-1:0] rd_exp_q [$];
   int  n_checks = 0;
   int  n_fail   = 0;
   bit  mem_rnd_en = 1'b0;

   initial forever begin
      @(posedge clk_i); #1;
      if (mem_rnd_en) mem_ready_i = ($urandom_range(0, 3) != 0);
   end

   task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] l);
      int g;
      g = 0;
      cmd_wr_i = wr; cmd_addr_i = a; cmd_len_i = l; cmd_valid_i = 1'b1;
      while (!cmd_ready_o && g < 50) begin @(negedge clk_i); g++; end
      n_checks++;
      if (cmd_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL cmd_accept: cmd_ready_o=%0b after %0d cycles, required 1", cmd_ready_o, g);
      end
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l,
                           input logic [WIDTH-1:0] base, input int gap);
      logic [AW-1:0]    exa [$];
      logic [WIDTH-1:0] exd [$];
      int k, g, cyc, viol, d0;
      bit pending, saw_done, hs_wr, hs_mem;
      wlog_addr.delete(); wlog_data.delete();
      d0 = done_cnt;
      for (int i = 0; i <= int'(l); i++) begin
         exa.push_back(a + AW'(i));
         exd.push_back(base + WIDTH'(i));
         ref_mem[a + AW'(i)] = base + WIDTH'(i);
      end
      send_cmd(1'b1, a, l);
      k = 0; g = gap; cyc = 0; viol = 0; pending = 0; saw_done = 0;
      while (!saw_done && cyc < 500) begin
         if (k <= int'(l) && !wr_valid_i) begin
            if (g == 0) begin wr_valid_i = 1'b1; wr_data_i = base + WIDTH'(k); end
            else g--;
         end
         @(negedge clk_i); cyc++;
         if (mem_valid_o && !pending) viol++;
         if (done_o) saw_done = 1;
         else begin
            hs_wr  = wr_valid_i && wr_ready_o;
            hs_mem = mem_valid_o && mem_ready_i;
            @(posedge clk_i); #1;
            if (hs_wr) begin wr_valid_i = 1'b0; k++; g = gap; pending = 1; end
            if (hs_mem) pending = 0;
         end
      end
      n_checks++;
      if (saw_done !== 1'b1) begin n_fail++; $display("FAIL wr_done: done_o not seen within %0d cycles, required within 500", cyc); end
      n_checks++;
      if (viol !== 0) begin n_fail++; $display("FAIL wr_req_before_data: %0d mem_valid_o cycles without accepted data, required 0", viol); end
      n_checks++;
      if (cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL wr_done_cmd_ready: got %0b required 0", cmd_ready_o); end
      n_checks++;
      if (wlog_addr.size() !== exa.size()) begin
         n_fail++; $display("FAIL wr_count: %0d memory writes, required %0d", wlog_addr.size(), exa.size());
      end
      for (int i = 0; i < exa.size() && i < wlog_addr.size(); i++) begin
         n_checks++;
         if (wlog_addr[i] !== exa[i] || wlog_data[i] !== exd[i]) begin
            n_fail++; $display("FAIL wr_word%0d: addr %h data %h, required addr %h data %h", i, wlog_addr[i], wlog_data[i], exa[i], exd[i]);
         end
      end
      @(posedge clk_i); #1;
      n_checks++;
      if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL wr_done_pulses: %0d pulses, required 1", done_cnt - d0); end
      @(negedge clk_i);
      n_checks++;
      if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL wr_back_idle: busy=%0b cmd_ready=%0b, required 0/1", busy_o, cmd_ready_o);
      end
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l,
                          input int stall_word, input int stall_n);
      logic [WIDTH-1:0] exp, hold;
      int g, d0;
      bit stable;
      d0 = done_cnt;
      for (int i = 0; i <= int'(l); i++) rd_exp_q.push_back(ref_mem[a + AW'(i)]);
      send_cmd(1'b0, a, l);
      rd_ready_i = 1'b1;
      for (int k = 0; k <= int'(l); k++) begin
         exp = rd_exp_q.pop_front();
         if (k == stall_word) rd_ready_i = 1'b0;
         g = 0;
         @(negedge clk_i);
         while (!rd_valid_o && g < 100) begin @(negedge clk_i); g++; end
         if (rd_valid_o !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL rd_valid_wait: rd_valid_o=%0b after %0d cycles on word %0d, required 1", rd_valid_o, g, k);
            rd_exp_q.delete();
            return;
         end
         if (k == stall_word) begin
            hold = rd_data_o; stable = 1;
            // A command offered while busy must be ignored.
            cmd_valid_i = 1'b1; cmd_wr_i = 1'b1; cmd_addr_i = 4'h9; cmd_len_i = '0;
            repeat (stall_n) begin
               @(negedge clk_i);
               if (!rd_valid_o || rd_data_o !== hold || mem_valid_o || cmd_ready_o) stable = 0;
            end
            n_checks++;
            if (stable !== 1'b1) begin
               n_fail++; $display("FAIL rd_stall_hold: valid=%0b data=%h mem_valid=%0b cmd_ready=%0b, required 1/%h/0/0",
                                  rd_valid_o, rd_data_o, mem_valid_o, cmd_ready_o, hold);
            end
            cmd_valid_i = 1'b0; rd_ready_i = 1'b1;
         end
         n_checks++;
         if (rd_data_o !== exp || rd_last_o !== (k == int'(l))) begin
            n_fail++; $display("FAIL rd_word%0d: data %h last %0b, required data %h last %0b", k, rd_data_o, rd_last_o, exp, (k == int'(l)));
         end
         @(posedge clk_i); #1;
      end
      @(negedge clk_i);
      n_checks++;
      if (done_o !== 1'b1) begin n_fail++; $display("FAIL rd_done: done_o=%0b, required 1", done_o); end
      @(posedge clk_i); #1;
      n_checks++;
      if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL rd_done_pulses: %0d pulses, required 1", done_cnt - d0); end
      @(negedge clk_i);
      n_checks++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rd_back_idle: busy=%0b, required 0", busy_o); end
   endtask

   task automatic test_reset();
      clr_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 clr_i = 1'b0;
      @(negedge clk_i);
      n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %0b required 1", cmd_ready_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b required 0", busy_o); end
      n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b required 0", done_o); end
      n_checks++; if (mem_valid_o !== 1'b0 || mem_wr_rd_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid: got %0b/%0b required 0/0", mem_valid_o, mem_wr_rd_en_o); end
      n_checks++; if (mem_addr_o !== '0) begin n_fail++; $display("FAIL rst_mem_addr: got %h required 0", mem_addr_o); end
      n_checks++; if (mem_wdata_o !== '0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h required 0", mem_wdata_o); end
      n_checks++; if (rd_data_o !== '0) begin n_fail++; $display("FAIL rst_rd_data: got %h required 0", rd_data_o); end
      n_checks++; if (rd_valid_o !== 1'b0 || rd_last_o !== 1'b0 || wr_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL rst_handshakes: rd_valid=%0b rd_last=%0b wr_ready=%0b required 0/0/0", rd_valid_o, rd_last_o, wr_ready_o);
      end
   endtask

   task automatic test_full_burst();
      mem_rnd_en = 1'b1;
      do_write(4'd0, 4'd15, 8'h10, 0);
      do_read(4'd0, 4'd15, -1, 0);
   endtask

   task automatic test_wrap();
      do_write(4'd14, 4'd3, 8'hA0, 0);
      do_read(4'd14, 4'd3, -1, 0);
   endtask

   task automatic test_read_stall();
      mem_rnd_en = 1'b0; mem_ready_i = 1'b1;
      do_read(4'd0, 4'd5, 1, 5);
   endtask

   task automatic test_write_gaps();
      mem_rnd_en = 1'b0; mem_ready_i = 1'b1;
      do_write(4'd4, 4'd4, 8'h50, 3);
      mem_rnd_en = 1'b1;
      do_read(4'd4, 4'd4, -1, 0);
      mem_rnd_en = 1'b0; mem_ready_i = 1'b1;
   endtask

   task automatic test_abort();
      int k, cyc, d0;
      mem_rnd_en = 1'b0; mem_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) ref_mem[i] = 8'h70 + WIDTH'(i);
      d0 = done_cnt;
      send_cmd(1'b1, 4'd0, 4'd15);
      k = 0; cyc = 0;
      while (k < 5 && cyc < 100) begin
         wr_valid_i = 1'b1; wr_data_i = 8'h70 + WIDTH'(k);
         @(negedge clk_i); cyc++;
         if (wr_ready_o) begin @(posedge clk_i); #1; wr_valid_i = 1'b0; k++; end
         else begin @(posedge clk_i); #1; end
      end
      wr_valid_i = 1'b0;
      n_checks++; if (k !== 5) begin n_fail++; $display("FAIL abort_feed: %0d words accepted, required 5", k); end
      clr_i = 1'b1;
      @(posedge clk_i); #1 clr_i = 1'b0;
      @(negedge clk_i);
      n_checks++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_idle: cmd_ready=%0b busy=%0b required 1/0", cmd_ready_o, busy_o); end
      n_checks++; if (mem_valid_o !== 1'b0 || mem_addr_o !== '0) begin n_fail++; $display("FAIL abort_mem: valid=%0b addr=%h required 0/0", mem_valid_o, mem_addr_o); end
      repeat (3) @(negedge clk_i);
      n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL abort_no_done: %0d done pulses, required 0", done_cnt - d0); end
      do_read(4'd0, 4'd3, -1, 0);
   endtask

`ifdef MEM_BURST_TIMEOUT_EN
   task automatic test_timeout();
      int n, g;
      mem_rnd_en = 1'b0; mem_ready_i = 1'b0;
      send_cmd(1'b0, 4'd2, 4'd0);
      n = 0; g = 0;
      @(negedge clk_i);
      while (!done_o && g < 40) begin if (mem_valid_o) n++; @(negedge clk_i); g++; end
      n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL to_done: done_o=%0b, required 1", done_o); end
      n_checks++; if (n !== 8) begin n_fail++; $display("FAIL to_cycles: %0d request cycles, required 8", n); end
      n_checks++; if (err_o !== 1'b1 || mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL to_err: err=%0b mem_valid=%0b required 1/0", err_o, mem_valid_o); end
      @(posedge clk_i); #1;
      @(negedge clk_i);
      n_checks++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL to_sticky: err=%0b busy=%0b required 1/0", err_o, busy_o); end
      mem_ready_i = 1'b1;
      rd_ready_i = 1'b1;
      send_cmd(1'b0, 4'd2, 4'd0);
      @(negedge clk_i);
      n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL to_err_clear: err=%0b required 0", err_o); end
      g = 0;
      while (busy_o && g < 20) begin @(negedge clk_i); g++; end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL to_drain: busy=%0b required 0", busy_o); end
   endtask
`endif

   initial begin
      clr_i = 1'b1; cmd_valid_i = 1'b0; cmd_wr_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
      wr_valid_i = 1'b0; wr_data_i = '0; rd_ready_i = 1'b0; mem_ready_i = 1'b1;
      test_reset();
      test_full_burst();
      test_wrap();
      test_read_stall();
      test_write_gaps();
      test_abort();
`ifdef MEM_BURST_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Upstream request sequencer for the single-port SRAM `memory` block.
- Accepts one burst command (direction, start address, word count), then streams write data into the SRAM or streams read data out of it.
- Each word is one valid/ready transaction on the SRAM port, using the memory's existing protocol (valid_i, wr_rd_en_i, addr_i, wdata_i, ready_o, rdata_o).
- Replaces the bench-style fd_write/fd_read task loops with synthesizable RTL.

Parameters:
- WIDTH, 8, data word width; must match the memory.
- DEPTH, 16, number of memory locations.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with MEM_BURST_TIMEOUT_EN.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- clr_i  in  1  reset; synchronous, active-high.
- cmd_valid_i  in  1  burst command present.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_wr_i  in  1  1 = write burst, 0 = read burst.
- cmd_addr_i  in  ADDR_WIDTH  start address.
- cmd_len_i  in  ADDR_WIDTH  increment count; words in burst = cmd_len_i+1.
- wr_valid_i  in  1  write data present.
- wr_ready_o  out  1  write data accepted.
- wr_data_i  in  WIDTH  write data.
- rd_valid_o  out  1  read data present.
- rd_ready_i  in  1  downstream accepts read data.
- rd_data_o  out  WIDTH  read data.
- rd_last_o  out  1  final word of the burst; qualified by rd_valid_o.
- mem_valid_o  out  1  to memory valid_i.
- mem_wr_rd_en_o  out  1  to memory wr_rd_en_i (1 = write).
- mem_addr_o  out  ADDR_WIDTH  to memory addr_i.
- mem_wdata_o  out  WIDTH  to memory wdata_i.
- mem_ready_i  in  1  from memory ready_o.
- mem_rdata_i  in  WIDTH  from memory rdata_o.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at burst end.

Behaviour:
- Reset (clr_i=1 at a rising edge):
  - State goes to IDLE; address/count/data registers are cleared.
  - Resulting outputs: cmd_ready_o=1, all other outputs 0 (including mem_addr_o, mem_wdata_o, rd_data_o).
  - Reset mid-burst aborts immediately; no done_o pulse is produced.
- Handshakes:
  - A transfer occurs on a rising edge where valid and ready are both high.
  - Every valid output holds, with stable payload, until its handshake completes.
- Memory transaction:
  - Completes on an edge where mem_valid_o && mem_ready_i.
  - Read data is sampled from mem_rdata_i on that same edge.
- FSM states and transitions (Moore outputs decoded from registered state):
  - IDLE: cmd_ready_o=1. On cmd_valid_i, latch addr, len and dir, and clear cnt. Next state is WR_FETCH if cmd_wr_i, else RD_REQ.
  - WR_FETCH: wr_ready_o=1. On wr_valid_i, latch the data and go to WR_REQ.
  - WR_REQ: mem_valid_o=1, mem_wr_rd_en_o=1. On mem_ready_i: if cnt==len go to DONE; otherwise addr+1, cnt+1, go to WR_FETCH.
  - RD_REQ: mem_valid_o=1, mem_wr_rd_en_o=0. On mem_ready_i, capture rdata and go to RD_OUT.
  - RD_OUT: rd_valid_o=1; rd_last_o=(cnt==len). On rd_ready_i: if last go to DONE; otherwise addr+1, cnt+1, go to RD_REQ.
  - DONE: done_o=1 for one cycle, then IDLE. cmd_ready_o=0 in this state.
- Throughput:
  - Minimum 2 cycles per word plus 1 DONE cycle.
  - Minimum command-to-first-memory-request latency: 1 cycle for reads, 2 cycles for writes.
- Address arithmetic:
  - Modulo 2^ADDR_WIDTH, so DEPTH-1 wraps to 0.
  - cnt is ADDR_WIDTH+1 bits wide, so len=DEPTH-1 (full memory) is representable.
- Boundary conditions:
  - cmd_valid_i is ignored while busy.
  - Write data starvation holds WR_FETCH indefinitely; read backpressure holds RD_OUT indefinitely. Neither issues any memory request meanwhile.
  - mem_ready_i is ignored while mem_valid_o=0.
  - len=0 produces a single-word burst.

Optional Feature:
- Macro MEM_BURST_TIMEOUT_EN.
- Defined:
  - Adds output port err_o (1 bit).
  - A watchdog counter counts consecutive cycles in WR_REQ/RD_REQ without mem_ready_i; it clears on each memory handshake.
  - When the count reaches TIMEOUT_CYCLES, the block drops mem_valid_o, goes to DONE, and asserts err_o alongside done_o.
  - err_o is sticky until the next accepted command or reset.
- Undefined: no counter and no err_o port; the block waits on the memory forever.

Decomposition:
- Package mem_burst_pkg:
  - state enum (IDLE, WR_FETCH, WR_REQ, RD_REQ, RD_OUT, DONE);
  - direction constants DIR_RD=0, DIR_WR=1.
- Sub-module mem_burst_addr_gen:
  - address and count registers with load, increment and last-compare;
  - the FSM instantiates it.

Test Plan:
- Write burst addr=0, len=15, data 8'h10..8'h1F, then read burst addr=0, len=15 → rd_data_o returns 8'h10..8'h1F in order; rd_last_o only on the 16th word; done_o pulses once per burst.
- Write burst addr=14, len=3 → memory sees addresses 14, 15, 0, 1; read back of the same range matches.
- Read burst with rd_ready_i held low for 5 cycles on word 2 → rd_data_o stable; no mem_valid_o during the stall; no words lost or duplicated.
- Write burst with wr_valid_i gaps of 3 cycles → mem_valid_o asserts only after each data accept; memory contents correct.
- clr_i asserted during word 5 of a 16-word write → next cycle is IDLE with cmd_ready_o=1; no done_o; a new command is accepted.
- With MEM_BURST_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready_i tied low → done_o and err_o assert 8 cycles after mem_valid_o rises; err_o clears on the next command.
